// File: rtl/stack_map_tx.sv
// stack_map_tx: transmit-side symbol order reverser (frame LIFO).
// Frames of DEPTH symbols are written into one of two ping-pong banks in
// arrival order and drained last-in-first-out, so one frame can fill while
// the previous one drains.
// Optional build macro: STACK_MAP_TX_OVF_EN adds a sticky overflow flag (ovf)
// and an 8-bit saturating drop counter (drop_cnt) for in_valid & !in_ready.
module stack_map_tx #(
  parameter int DATA  = 12,
  parameter int DEPTH = 48,
  parameter int AD    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  input  logic            out_ready,
  output logic            out_last,
`ifdef STACK_MAP_TX_OVF_EN
  output logic            ovf,
  output logic [7:0]      drop_cnt,
`endif
  output logic            busy
);

  localparam logic [AD-1:0] LAST_IDX = AD'(DEPTH - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    DRAINING = 2'd2
  } bank_state_t;

  bank_state_t     state      [2];
  bank_state_t     state_next [2];
  logic            wbank, wbank_next;
  logic            rbank, rbank_next;
  logic [AD-1:0]   wcnt, wcnt_next;
  logic [AD-1:0]   rcnt, rcnt_next;
  logic            accept;
  logic            load;
  logic            busy_next;
  logic [DATA-1:0] rd_data;

  // Symbol storage; contents survive reset on purpose (only pointers clear).
  logic [DATA-1:0] mem [2][DEPTH];

  // The write bank is only ever EMPTY while filling and the read bank only
  // FULL/DRAINING while draining, so the two sides can never touch one bank.
  assign in_ready = (state[wbank] == EMPTY);
  assign accept   = in_valid & in_ready;
  assign load     = (!out_valid | out_ready) &
                    ((state[rbank] == FULL) | (state[rbank] == DRAINING));
  assign rd_data  = mem[rbank][rcnt];

  // Next-state for bank states and both pointer pairs.
  always_comb begin
    state_next[0] = state[0];
    state_next[1] = state[1];
    wbank_next    = wbank;
    wcnt_next     = wcnt;
    rbank_next    = rbank;
    rcnt_next     = rcnt;

    if (accept) begin
      if (wcnt == LAST_IDX) begin
        state_next[wbank] = FULL;
        wcnt_next         = '0;
        wbank_next        = ~wbank;
      end else begin
        wcnt_next = wcnt + AD'(1);
      end
    end

    if (load) begin
      if (rcnt == '0) begin
        state_next[rbank] = EMPTY;
        rbank_next        = ~rbank;
        rcnt_next         = LAST_IDX;
      end else begin
        state_next[rbank] = DRAINING;
        rcnt_next         = rcnt - AD'(1);
      end
    end

    busy_next = (state_next[0] != EMPTY) | (state_next[1] != EMPTY) |
                (wcnt_next != '0);
  end

  // Memory write port: no reset, a freshly reset bank is simply overwritten.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wbank][wcnt] <= in_data;
    end
  end

  // Control state, pointers and registered output stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wcnt      <= '0;
      rcnt      <= LAST_IDX;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state[0] <= state_next[0];
      state[1] <= state_next[1];
      wbank    <= wbank_next;
      rbank    <= rbank_next;
      wcnt     <= wcnt_next;
      rcnt     <= rcnt_next;
      busy     <= busy_next;
      if (load) begin
        out_data  <= rd_data;
        out_valid <= 1'b1;
        out_last  <= (rcnt == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef STACK_MAP_TX_OVF_EN
  // Sticky overflow flag and saturating drop counter for refused symbols.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (in_valid & !in_ready) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stack_map_tx.sv
// tb_stack_map_tx: directed self-checking bench for stack_map_tx.
// A scoreboard collects accepted symbols per frame and queues each frame in
// reverse order; every output handshake is checked against that queue.
// Build with STACK_MAP_TX_OVF_EN defined to also check ovf/drop_cnt.
module tb_stack_map_tx;

  localparam int DATA  = 12;
  localparam int DEPTH = 48;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [DATA-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [DATA-1:0] out_data;
  logic            out_ready;
  logic            out_last;
  logic            busy;
`ifdef STACK_MAP_TX_OVF_EN
  logic            ovf;
  logic [7:0]      drop_cnt;
`endif

  stack_map_tx #(.DATA(DATA), .DEPTH(DEPTH), .AD(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef STACK_MAP_TX_OVF_EN
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA-1:0] exp_q[$];
  logic [DATA-1:0] frame_buf[$];
  int              cyc = 0;
  int              out_idx = 0;
  int              n_out = 0;
  int              first_out_cyc = 0;
  int              last_out_cyc = 0;
  int              full_cyc = 0;
  int              hold_evts = 0;
  logic            last_acc = 1'b0;
  logic            stall_prev = 1'b0;
  logic [DATA-1:0] stall_data = '0;
  logic            stall_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_out = 0;
    first_out_cyc = 0;
    last_out_cyc = 0;
    full_cyc = 0;
    hold_evts = 0;
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    logic [DATA-1:0] e;
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, stall_data);
      check("hold_last", out_last, stall_last);
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
    if (in_valid && !in_ready) hold_evts++;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (n_out == 1) first_out_cyc = cyc;
      last_out_cyc = cyc;
      $display("OUT  t=%0t data=0x%03h last=%0d", $time, out_data, out_last);
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e);
        check("out_last", out_last, (out_idx % DEPTH) == DEPTH - 1);
        out_idx++;
      end
    end
    if (last_acc) begin
      frame_buf.push_back(in_data);
      if (frame_buf.size() == DEPTH) begin
        for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(frame_buf[i]);
        frame_buf.delete();
        full_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_ready(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Offer n consecutive symbols base, base+1, ... ; mode: 0 ready low, 1 high, 2 random.
  task automatic drive(input int n, input int base, input int mode);
    int sent = 0;
    int k = 0;
    while (sent < n && k < 4000) begin
      in_valid  = 1'b1;
      in_data   = DATA'(base + sent);
      out_ready = pick_ready(mode);
      tick();
      if (last_acc) sent++;
      k++;
    end
    in_valid = 1'b0;
    check("drive_done", sent, n);
  endtask

  task automatic drain(input int mode);
    int k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      out_ready = pick_ready(mode);
      tick();
      k++;
    end
    check("drain_done", exp_q.size(), 0);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int sent;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // One frame 0x000..0x02F with out_ready high.
    clear_stats();
    out_ready = 1'b1;
    drive(DEPTH, 'h000, 1);
    drain(1);
    // 48th accept is seen at the falling edge before edge P; out_valid rises
    // at P+1 and is first seen two falling edges after the accept.
    check("first_latency", first_out_cyc - full_cyc, 2);
    check("burst_len", last_out_cyc - first_out_cyc, DEPTH - 1);
    check("frame1_count", n_out, DEPTH);
    check("idle_busy", busy, 0);

    // Three frames back to back, in_ready must never drop.
    clear_stats();
    drive(3 * DEPTH, 'h040, 1);
    drain(1);
    check("stream_stalls", hold_evts, 0);
    check("stream_count", n_out, 3 * DEPTH);

    // Backpressure: out_ready low for 100 cycles of continuous input.
    clear_stats();
    sent = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid  = 1'b1;
      in_data   = DATA'(sent);
      out_ready = 1'b0;
      tick();
      if (last_acc) sent++;
`ifdef STACK_MAP_TX_OVF_EN
      if (c == 95) check("ovf_before", ovf, 0);
`endif
    end
    in_valid = 1'b0;
    check("bp_accepted", sent, 2 * DEPTH);
    check("bp_refused", hold_evts, 4);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_data", out_data, 'h02F);
    check("bp_busy", busy, 1);
`ifdef STACK_MAP_TX_OVF_EN
    check("ovf_set", ovf, 1);
    check("drop_cnt", drop_cnt, 4);
`endif
    drain(1);
    check("bp_count", n_out, 2 * DEPTH);

    // Random downstream readiness.
    clear_stats();
    drive(2 * DEPTH, 'h200, 2);
    drain(2);
    check("rand_count", n_out, 2 * DEPTH);

    // Reset while frame 1 drains and frame 2 holds 20 symbols.
    clear_stats();
    drive(DEPTH + 20, 'h300, 1);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last", out_last, 0);
    check("arst_out_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
`ifdef STACK_MAP_TX_OVF_EN
    check("arst_ovf", ovf, 0);
    check("arst_drop_cnt", drop_cnt, 0);
`endif
    exp_q.delete();
    frame_buf.delete();
    out_idx = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    drive(DEPTH, 'h100, 1);
    drain(1);
    check("post_rst_count", n_out, DEPTH);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
